pool_layer_strided: RTL and testbench

//  Streaming KxK pooling stage with configurable stride and max/avg mode, for use

---
 rtl/pool_pkg.sv | 26 ++
 rtl/pool_layer_strided_reduce.sv | 59 +++++
 rtl/pool_layer_strided.sv | 169 ++++++++++++++++
 tb/tb_pool_layer_strided.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
`default_nettype none
// pool_pkg: shared enums and sizing helpers for the strided KxK pooling stage. (rev 1.0)
package pool_pkg;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   // Accumulator width that holds K*K samples without overflow.
   function automatic int sum_width(input int data_size, input int k);
      return data_size + $clog2(k * k);
   endfunction

   function automatic int out_dim(input int img, input int k, input int s);
      return (img - k) / s + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pool_layer_strided_reduce.sv
`default_nettype none
// pool_reduce: combinational max or average over one channel's KxK window. (rev 1.0)
module pool_reduce
   import pool_pkg::*;
#(
   parameter int DATA_SIZE  = 8,
   parameter int KERNEL_DIM = 3,
   parameter int POOL_MODE  = 0,
   parameter int SIGNED     = 0
) (
   input  logic [KERNEL_DIM*KERNEL_DIM*DATA_SIZE-1:0] window,
   output logic [DATA_SIZE-1:0]                       result
);

   localparam int   KK        = KERNEL_DIM * KERNEL_DIM;
   localparam int   SW        = sum_width(DATA_SIZE, KERNEL_DIM);
   localparam logic IS_SIGNED = (SIGNED != 0);

   generate
      if (POOL_MODE == int'(POOL_AVG)) begin : g_avg
         // One spare bit keeps the divisor positive when the division is signed.
         localparam logic [SW:0] DIVISOR = (SW + 1)'(KK);
         logic [SW:0] sum;

         always_comb begin
            sum = '0;
            for (int i = 0; i < KK; i++) begin
               sum = sum + {{(SW + 1 - DATA_SIZE){IS_SIGNED & window[i*DATA_SIZE + DATA_SIZE - 1]}},
                            window[i*DATA_SIZE +: DATA_SIZE]};
            end
         end

         if (SIGNED != 0) begin : g_sdiv
            assign result = DATA_SIZE'($signed(sum) / $signed(DIVISOR));
         end else begin : g_udiv
            assign result = DATA_SIZE'(sum / DIVISOR);
         end
      end else begin : g_max
         localparam logic [DATA_SIZE-1:0] MIN_VAL = {IS_SIGNED, {(DATA_SIZE - 1){1'b0}}};
         logic [DATA_SIZE-1:0] best;
         logic [DATA_SIZE-1:0] elem;

         always_comb begin
            best = MIN_VAL;
            elem = '0;
            for (int i = 0; i < KK; i++) begin
               elem = window[i*DATA_SIZE +: DATA_SIZE];
               if (IS_SIGNED ? ($signed(elem) > $signed(best)) : (elem > best)) begin
                  best = elem;
               end
            end
         end

         assign result = best;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/pool_layer_strided.sv
`default_nettype none
// pool_layer_strided: streaming KxK max/avg pooling with stride over a square frame,
// one pixel (all channels) per cycle, emitting only stride-aligned full windows. (rev 1.0)
module pool_layer_strided
   import pool_pkg::*;
#(
   parameter int DATA_SIZE      = 8,
   parameter int INPUT_CHANNELS = 256,
   parameter int IMG_DIM        = 13,
   parameter int KERNEL_DIM     = 3,
   parameter int STRIDE         = 2,
   parameter int POOL_MODE      = 0,
   parameter int SIGNED         = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                i_start,
   input  logic [INPUT_CHANNELS-1:0]           i_ibuf_we,
   input  logic [DATA_SIZE*INPUT_CHANNELS-1:0] i_ibuf_wr_data,
   output logic                                o_ready,
   input  logic                                i_next_ready,
   output logic [DATA_SIZE*INPUT_CHANNELS-1:0] o_next_data,
   output logic [INPUT_CHANNELS-1:0]           o_next_we,
   output logic                                o_next_start,
   output logic                                o_done,
   output logic                                o_err
);

   localparam int K        = KERNEL_DIM;
   localparam int KK       = K * K;
   localparam int FIFO_LEN = IMG_DIM * (K - 1) + K;
   localparam int PIX_W    = DATA_SIZE * INPUT_CHANNELS;
   localparam int CW       = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
   localparam int PW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   localparam logic [CW-1:0] LAST_POS   = CW'(IMG_DIM - 1);
   localparam logic [CW-1:0] WIN_EDGE   = CW'(K - 1);
   localparam logic [PW-1:0] LAST_PHASE = PW'(STRIDE - 1);

   state_e               state;
   logic [CW-1:0]        col;
   logic [CW-1:0]        row;
   logic [PW-1:0]        col_phase;
   logic [PW-1:0]        row_phase;
   logic                 win_valid;
   logic                 accept;
   logic                 partial_we;
   logic                 pos_valid;
   logic [PIX_W-1:0]     fifo [FIFO_LEN];
   logic [KK*DATA_SIZE-1:0] window  [INPUT_CHANNELS];
   logic [DATA_SIZE-1:0]    reduced [INPUT_CHANNELS];

   function automatic logic [PW-1:0] step_phase(input logic [PW-1:0] p);
      return (p == LAST_PHASE) ? '0 : p + 1'b1;
   endfunction

   assign o_ready    = i_next_ready && (state == RUN);
   assign accept     = o_ready && (&i_ibuf_we);
   assign partial_we = (|i_ibuf_we) && !(&i_ibuf_we);
   // Phases sit at 0 until the window edge is reached, so phase 0 means stride-aligned.
   assign pos_valid  = (row >= WIN_EDGE) && (col >= WIN_EDGE) &&
                       (row_phase == '0) && (col_phase == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         col          <= '0;
         row          <= '0;
         col_phase    <= '0;
         row_phase    <= '0;
         win_valid    <= 1'b0;
         o_next_start <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         o_next_start <= 1'b0;
         o_done       <= 1'b0;
         win_valid    <= accept && pos_valid;
         if ((state == RUN) && partial_we) begin
            o_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (i_start) begin
                  state        <= RUN;
                  o_next_start <= 1'b1;
                  col          <= '0;
                  row          <= '0;
                  col_phase    <= '0;
                  row_phase    <= '0;
               end
            end
            RUN: begin
               if (accept) begin
                  if (col == LAST_POS) begin
                     col       <= '0;
                     col_phase <= '0;
                     if (row == LAST_POS) begin
                        state <= FLUSH;
                     end else begin
                        row       <= row + 1'b1;
                        row_phase <= (row >= WIN_EDGE) ? step_phase(row_phase) : '0;
                     end
                  end else begin
                     col       <= col + 1'b1;
                     col_phase <= (col >= WIN_EDGE) ? step_phase(col_phase) : '0;
                  end
               end
            end
            FLUSH: begin
               // Once no tag is in flight, the final result has already been registered.
               if (!win_valid) begin
                  state  <= IDLE;
                  o_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_LEN; i++) begin
            fifo[i] <= '0;
         end
      end else if (accept) begin
         fifo[0] <= i_ibuf_wr_data;
         for (int i = 1; i < FIFO_LEN; i++) begin
            fifo[i] <= fifo[i-1];
         end
      end
   end

   generate
      for (genvar c = 0; c < INPUT_CHANNELS; c++) begin : g_ch
         for (genvar e = 0; e < KK; e++) begin : g_el
            assign window[c][e*DATA_SIZE +: DATA_SIZE] =
               fifo[(e / K) * IMG_DIM + (e % K)][c*DATA_SIZE +: DATA_SIZE];
         end

         pool_reduce #(
            .DATA_SIZE  (DATA_SIZE),
            .KERNEL_DIM (KERNEL_DIM),
            .POOL_MODE  (POOL_MODE),
            .SIGNED     (SIGNED)
         ) u_reduce (
            .window (window[c]),
            .result (reduced[c])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_next_data <= '0;
         o_next_we   <= '0;
      end else begin
         o_next_we <= {INPUT_CHANNELS{win_valid}};
         if (win_valid) begin
            for (int c = 0; c < INPUT_CHANNELS; c++) begin
               o_next_data[c*DATA_SIZE +: DATA_SIZE] <= reduced[c];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pool_layer_strided.sv
`default_nettype none
// tb_pool_layer_strided: drives identical frames into max/avg x unsigned/signed variants
// and compares every pooled output with a window-arithmetic reference model.
module tb_pool_layer_strided;
   import pool_pkg::*;

   localparam int D    = 8;
   localparam int CH   = 8;
   localparam int IMG  = 8;
   localparam int K    = 3;
   localparam int S    = 2;
   localparam int NDUT = 4;
   localparam int OD   = out_dim(IMG, K, S);
   localparam int NPIX = IMG * IMG;

   logic            clk        = 1'b0;
   logic            rst_n      = 1'b0;
   logic            start      = 1'b0;
   logic            next_ready = 1'b0;
   logic [CH-1:0]   we         = '0;
   logic [D*CH-1:0] wr_data    = '0;

   logic            rdy    [NDUT];
   logic [D*CH-1:0] nd     [NDUT];
   logic [CH-1:0]   nw     [NDUT];
   logic            nstart [NDUT];
   logic            ndone  [NDUT];
   logic            nerr   [NDUT];

   always #5 clk = ~clk;

   // Variant index d: mode = d/2 (0 max, 1 avg), signed = d%2.
   generate
      for (genvar g = 0; g < NDUT; g++) begin : g_dut
         pool_layer_strided #(
            .DATA_SIZE      (D),
            .INPUT_CHANNELS (CH),
            .IMG_DIM        (IMG),
            .KERNEL_DIM     (K),
            .STRIDE         (S),
            .POOL_MODE      (g / 2),
            .SIGNED         (g % 2)
         ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_start        (start),
            .i_ibuf_we      (we),
            .i_ibuf_wr_data (wr_data),
            .o_ready        (rdy[g]),
            .i_next_ready   (next_ready),
            .o_next_data    (nd[g]),
            .o_next_we      (nw[g]),
            .o_next_start   (nstart[g]),
            .o_done         (ndone[g]),
            .o_err          (nerr[g])
         );
      end
   endgenerate

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: records every output word and done pulse; only this process writes these.
   logic [D*CH-1:0] got    [NDUT][256];
   int              got_n  [NDUT];
   int              done_n [NDUT];
   int              bad_we [NDUT];

   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (nw[d] != '0) begin
            if (nw[d] != '1) bad_we[d]++;
            if (got_n[d] < 256) got[d][got_n[d]] = nd[d];
            got_n[d]++;
         end
         if (ndone[d]) done_n[d]++;
      end
   end

   // Reference model: pooled value straight from the frame image.
   logic [D-1:0] pix [NPIX][CH];

   function automatic int sval(input logic [D-1:0] v, input int sgn);
      return (sgn != 0) ? int'($signed(v)) : int'(v);
   endfunction

   function automatic logic [D-1:0] model_out(input int mode, input int sgn,
                                              input int oy, input int ox, input int ch);
      int best = -100000;
      int sum  = 0;
      int v;
      for (int dy = 0; dy < K; dy++) begin
         for (int dx = 0; dx < K; dx++) begin
            v = sval(pix[(oy * S + dy) * IMG + ox * S + dx][ch], sgn);
            sum += v;
            if (v > best) best = v;
         end
      end
      return (mode == 1) ? D'(sum / (K * K)) : D'(best);
   endfunction

   int base  [NDUT];
   int dbase [NDUT];
   int wbase [NDUT];

   function automatic bit all_done();
      for (int d = 0; d < NDUT; d++) begin
         if (done_n[d] <= dbase[d]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic check_idle(input string tag);
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("%s_d%0d_data", tag, d), nd[d], '0);
         check($sformatf("%s_d%0d_we", tag, d), nw[d], '0);
         check($sformatf("%s_d%0d_start", tag, d), nstart[d], '0);
         check($sformatf("%s_d%0d_done", tag, d), ndone[d], '0);
         check($sformatf("%s_d%0d_err", tag, d), nerr[d], '0);
         check($sformatf("%s_d%0d_ready", tag, d), rdy[d], '0);
      end
   endtask

   task automatic random_image();
      for (int p = 0; p < NPIX; p++)
         for (int c = 0; c < CH; c++)
            pix[p][c] = D'($urandom);
   endtask

   task automatic begin_frame();
      for (int d = 0; d < NDUT; d++) begin
         base[d]  = got_n[d];
         dbase[d] = done_n[d];
         wbase[d] = bad_we[d];
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int d = 0; d < NDUT; d++)
         check($sformatf("next_start_d%0d", d), nstart[d], 1);
   endtask

   task automatic feed(input int npix, input bit inject_err);
      int  idx    = 0;
      int  guard  = 0;
      int  stalls = 0;
      bit  errdone = 1'b0;
      bit  partial;
      bit  nr;
      while (idx < npix && guard < 4000) begin
         @(negedge clk);
         guard++;
         nr      = ($urandom_range(0, 4) != 0);
         partial = 1'b0;
         if (idx == 7 && stalls < 3) begin
            nr = 1'b0;
            stalls++;
         end
         if (inject_err && !errdone && idx == 5) begin
            partial = 1'b1;
            errdone = 1'b1;
            nr      = 1'b1;
         end
         next_ready = nr;
         we         = partial ? CH'(8'h0F) : '1;
         for (int c = 0; c < CH; c++) wr_data[c*D +: D] = pix[idx][c];
         #1;
         for (int d = 0; d < NDUT; d++)
            check($sformatf("o_ready_d%0d_px%0d", d, idx), rdy[d], nr);
         @(posedge clk);
         if (nr && !partial) idx++;
      end
      check("feed_timeout", idx, npix);
      @(negedge clk);
      next_ready = 1'b0;
      we         = '0;
   endtask

   task automatic end_frame(input string tag);
      for (int t = 0; t < 40 && !all_done(); t++) @(negedge clk);
      check($sformatf("%s_done_timeout", tag), all_done(), 1);
      repeat (3) @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("%s_d%0d_count", tag, d), got_n[d] - base[d], OD * OD);
         check($sformatf("%s_d%0d_done_pulses", tag, d), done_n[d] - dbase[d], 1);
         check($sformatf("%s_d%0d_we_uniform", tag, d), bad_we[d] - wbase[d], 0);
         for (int i = 0; i < OD * OD; i++) begin
            if (base[d] + i < got_n[d] && base[d] + i < 256) begin
               for (int c = 0; c < CH; c++)
                  check($sformatf("%s_d%0d_out%0d_ch%0d", tag, d, i, c),
                        got[d][base[d] + i][c*D +: D],
                        model_out(d / 2, d % 2, i / OD, i % OD, c));
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      // Frame 1: random image, random backpressure plus a forced 3-cycle stall.
      random_image();
      begin_frame();
      feed(NPIX, 1'b0);
      end_frame("f1");
      for (int d = 0; d < NDUT; d++) check($sformatf("f1_err_d%0d", d), nerr[d], 0);

      // Frame 2: all -5 with one -128 in the first window, plus a partial strobe.
      for (int p = 0; p < NPIX; p++)
         for (int c = 0; c < CH; c++)
            pix[p][c] = 8'hFB;
      for (int c = 0; c < CH; c++) pix[IMG + 1][c] = 8'h80;
      begin_frame();
      feed(NPIX, 1'b1);
      end_frame("f2");
      check("f2_signed_max_first", got[1][base[1] & 255][D-1:0], 8'hFB);
      for (int d = 0; d < NDUT; d++) check($sformatf("f2_err_d%0d", d), nerr[d], 1);

      // Frame 3: aborted by reset partway through.
      random_image();
      begin_frame();
      feed(20, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Frame 4: clean frame after the abort.
      random_image();
      begin_frame();
      feed(NPIX, 1'b0);
      end_frame("f4");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
